neuron_layer_scheduler: RTL

Sequences one shared fixed-point neuron datapath (N-input MAC + bias + ReLU, registered output) across the M neurons of a layer. Accepts one input vector over a valid/ready handshake and holds it. Per neuron it fetches that neuron's weight row and bias from an external synchronous weight memory, drives the neuron, waits out the neuron's pipeline latency, then streams the result out over a second valid/ready handshake. Sits between the layer input buffer and the per-layer output FIFO.

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/neuron_sched_perf.sv | 53 +++++
 rtl/neuron_layer_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron layer scheduler: default fixed-point widths,
// data/weight typedefs and the scheduler state encoding.
package neuron_pkg;

    localparam int DEF_QM = 6;
    localparam int DEF_QN = 10;
    localparam int DEF_WM = 6;
    localparam int DEF_WN = 10;

    localparam int DATA_W = DEF_QM + DEF_QN;
    localparam int WGT_W  = DEF_WM + DEF_WN;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [WGT_W-1:0]  wgt_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        COMPUTE,
        EMIT
    } sched_state_t;

endpackage

// File: rtl/neuron_sched_perf.sv
// Layer performance counters: cycles per layer (accept edge to final
// handshake, inclusive, latched at completion) and saturating count of
// backpressured result cycles.
module neuron_sched_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept_i,
    input  logic        stall_i,
    input  logic        done_i,
    output logic [31:0] perf_layer_cycles_o,
    output logic [31:0] perf_stall_cycles_o
);

    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] layer_q, layer_d;
    logic [31:0] stall_q, stall_d;

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            layer_q   <= '0;
            stall_q   <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
            layer_q   <= layer_d;
            stall_q   <= stall_d;
        end
    end

    // run_cnt_q holds the number of completed cycles since the accept edge,
    // so the current cycle is run_cnt_q + 1
    always_comb begin
        run_cnt_d = run_cnt_q;
        layer_d   = layer_q;
        stall_d   = stall_q;
        if (accept_i) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + 32'd1;
        end
        if (done_i) begin
            layer_d = run_cnt_q + 32'd1;
        end
        if (stall_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    assign perf_layer_cycles_o = layer_q;
    assign perf_stall_cycles_o = stall_q;

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Sequences a shared neuron datapath across the M neurons of a layer:
// accept vector, then per neuron fetch weights/bias, wait out the neuron
// latency, and stream the result out with its index.
// Optional perf counters are enabled with `define NEU_SCHED_PERF_EN.
module neuron_layer_scheduler
    import neuron_pkg::*;
#(
    parameter int N       = 2,
    parameter int M       = 4,
    parameter int QM      = 6,
    parameter int QN      = 10,
    parameter int WM      = 6,
    parameter int WN      = 10,
    parameter int NEU_LAT = 1,
    localparam int DW     = QM + QN,
    localparam int WW     = WM + WN,
    localparam int AW     = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0][DW-1:0] in_vec,
    output logic                 w_rd_en,
    output logic [AW-1:0]        w_addr,
    input  logic [N-1:0][WW-1:0] w_rdata,
    input  logic [DW-1:0]        b_rdata,
    output logic [N-1:0][DW-1:0] neu_in,
    output logic [N-1:0][WW-1:0] neu_weights,
    output logic [DW-1:0]        neu_bias,
    input  logic [DW-1:0]        neu_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [AW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 busy
`ifdef NEU_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_layer_cycles,
    output logic [31:0]          perf_stall_cycles
`endif
);

    localparam int CNT_W = (NEU_LAT < 1) ? 1 : $clog2(NEU_LAT + 1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(M - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(NEU_LAT);

    sched_state_t          state_q, state_d;
    logic [AW-1:0]         j_q, j_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N-1:0][DW-1:0]  neu_in_q, neu_in_d;
    logic [N-1:0][WW-1:0]  neu_w_q, neu_w_d;
    logic [DW-1:0]         neu_b_q, neu_b_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic                  is_last;

    assign is_last = (j_q == LAST_IDX);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            j_q        <= '0;
            cnt_q      <= '0;
            neu_in_q   <= '0;
            neu_w_q    <= '0;
            neu_b_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            neu_in_q   <= neu_in_d;
            neu_w_q    <= neu_w_d;
            neu_b_q    <= neu_b_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        neu_in_d   = neu_in_q;
        neu_w_d    = neu_w_q;
        neu_b_d    = neu_b_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neu_in_d = in_vec;
                    j_d      = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                neu_w_d = w_rdata;
                neu_b_d = b_rdata;
                cnt_d   = LAT_LOAD;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    out_data_d = neu_out;
                    state_d    = EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        j_d     = j_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign w_rd_en     = (state_q == FETCH);
    assign w_addr      = j_q;
    assign neu_in      = neu_in_q;
    assign neu_weights = neu_w_q;
    assign neu_bias    = neu_b_q;
    assign out_valid   = (state_q == EMIT);
    assign out_data    = out_data_q;
    assign out_idx     = j_q;
    assign out_last    = (state_q == EMIT) && is_last;

`ifdef NEU_SCHED_PERF_EN
    neuron_sched_perf u_perf (
        .clk                 (clk),
        .rst_n               (rst_n),
        .accept_i            ((state_q == IDLE) && in_valid),
        .stall_i             ((state_q == EMIT) && !out_ready),
        .done_i              ((state_q == EMIT) && out_ready && is_last),
        .perf_layer_cycles_o (perf_layer_cycles),
        .perf_stall_cycles_o (perf_stall_cycles)
    );
`endif

endmodule
